ttt_packet_io: RTL and testbench

- Parametrised host I/O front-end between the chip pins and the ticktocktokens main core.
- Assembles multi-beat instruction packets from a narrow input bus.
- Presents each packet as op/data to the core with a valid/ready handshake.
- Buffers core token events in a FIFO and drains them to the host as {proc, st/sp, stage} words, replacing the fixed one-cycle 16-bit pin mapping.

---
 rtl/ttt_io_pkg.sv | 27 ++
 rtl/ttt_packet_io_if.sv | 36 +++
 rtl/ttt_io_event_fifo.sv | 59 +++++
 rtl/ttt_packet_io.sv | 157 +++++++++++++++
 tb/tb_ttt_packet_io.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_io_pkg.sv
// rtl/ttt_io_pkg.sv - shared opcodes, stage codes and assembler state for the host I/O front-end
// Purpose: common definitions imported by ttt_packet_io and its submodules.
// Ports: none (package).
package ttt_io_pkg;

  localparam logic [3:0] OP_NOP              = 4'b0000;
  localparam logic [3:0] OP_INPUT            = 4'b0001;
  localparam logic [3:0] OP_ADVANCE          = 4'b0010;
  localparam logic [3:0] OP_PROG_DURATION    = 4'b1001;
  localparam logic [3:0] OP_PROG_GOOD_THRESH = 4'b1010;
  localparam logic [3:0] OP_PROG_BAD_THRESH  = 4'b1011;
  localparam logic [3:0] OP_NET_GOOD_W       = 4'b1100;
  localparam logic [3:0] OP_NET_BAD_W        = 4'b1101;
  localparam logic [3:0] OP_NET_INDPTR       = 4'b1110;
  localparam logic [3:0] OP_NET_INDICES      = 4'b1111;

  localparam logic [1:0] STAGE_IDLE    = 2'b00;
  localparam logic [1:0] STAGE_INPUT   = 2'b01;
  localparam logic [1:0] STAGE_ADVANCE = 2'b10;
  localparam logic [1:0] STAGE_OUTPUT  = 2'b11;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/ttt_packet_io_if.sv
// rtl/ttt_packet_io_if.sv - host/core handshake bundle for the packet front-end
// Purpose: groups the beat input, packet output and event/output-word signals.
// Ports: slave = front-end view (drives in_ready, pkt_*, out_*, overflow);
//        master = host/core view (drives in_*, pkt_ready, ev_*, stage, out_ready).
interface ttt_packet_io_if #(
  parameter int IN_WIDTH    = 8,
  parameter int PACKET_BITS = 16,
  parameter int OP_BITS     = 4,
  parameter int PROC_BITS   = 4
);
  logic [IN_WIDTH-1:0]            in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [OP_BITS-1:0]             pkt_op;
  logic [PACKET_BITS-OP_BITS-1:0] pkt_data;
  logic                           pkt_valid;
  logic                           pkt_ready;
  logic [PROC_BITS-1:0]           ev_proc;
  logic [1:0]                     ev_startstop;
  logic                           ev_valid;
  logic [1:0]                     stage;
  logic [PROC_BITS+3:0]           out_word;
  logic                           out_valid;
  logic                           out_ready;
  logic                           overflow;

  modport slave (
    input  in_data, in_valid, pkt_ready, ev_proc, ev_startstop, ev_valid, stage, out_ready,
    output in_ready, pkt_op, pkt_data, pkt_valid, out_word, out_valid, overflow
  );

  modport master (
    output in_data, in_valid, pkt_ready, ev_proc, ev_startstop, ev_valid, stage, out_ready,
    input  in_ready, pkt_op, pkt_data, pkt_valid, out_word, out_valid, overflow
  );
endinterface

// File: rtl/ttt_io_event_fifo.sv
// rtl/ttt_io_event_fifo.sv - registered event FIFO with sticky overflow flag
// Purpose: buffers token events; no fall-through, push-while-full drops and flags.
// Ports: clk, rst_n (sync active-low), push/push_data, pop, head (oldest entry),
//        full, empty, overflow (sticky until reset).
module ttt_io_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ttt_packet_io.sv
// rtl/ttt_packet_io.sv - host I/O front-end: beat-to-packet assembler and token event FIFO
// Purpose: assembles MSB-first beats into op/data packets with valid/ready, and
//          buffers core token events for the host as {proc, st/sp, stage} words.
// Ports: clk, rst_n (sync active-low), io (ttt_packet_io_if.slave),
//        timeout_pulse (only when TTT_PACKET_IO_TIMEOUT_EN is defined).
// Config: TTT_PACKET_IO_TIMEOUT_EN enables discarding a stalled partial packet.
module ttt_packet_io
  import ttt_io_pkg::*;
#(
  parameter int IN_WIDTH       = 8,
  parameter int PACKET_BITS    = 16,
  parameter int OP_BITS        = 4,
  parameter int PROC_BITS      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  ttt_packet_io_if.slave io
`ifdef TTT_PACKET_IO_TIMEOUT_EN
  ,
  output logic timeout_pulse
`endif
);
  localparam int BEATS = PACKET_BITS / IN_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EV_W  = PROC_BITS + 4;

  asm_state_t             state;
  logic [PACKET_BITS-1:0] shift;
  logic [PACKET_BITS-1:0] shift_next;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   pkt_valid_q;
  logic                   in_ready_q;
  logic                   last_beat;

  generate
    if (BEATS == 1) begin : g_single_beat
      assign shift_next = in_data_ext(io.in_data);
    end else begin : g_multi_beat
      assign shift_next = {shift[PACKET_BITS-IN_WIDTH-1:0], io.in_data};
    end
  endgenerate

  function automatic logic [PACKET_BITS-1:0] in_data_ext(input logic [IN_WIDTH-1:0] d);
    return PACKET_BITS'(d);
  endfunction

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

`ifdef TTT_PACKET_IO_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] idle_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= COLLECT;
      shift       <= '0;
      beat_cnt    <= '0;
      pkt_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef TTT_PACKET_IO_TIMEOUT_EN
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef TTT_PACKET_IO_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        COLLECT: begin
          if (io.in_valid) begin
            shift <= shift_next;
`ifdef TTT_PACKET_IO_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (last_beat) begin
              state       <= HOLD;
              beat_cnt    <= '0;
              pkt_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
`ifdef TTT_PACKET_IO_TIMEOUT_EN
          // Idle time only counts while a packet is partly assembled.
          else if (beat_cnt != '0) begin
            if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              beat_cnt      <= '0;
              shift         <= '0;
              idle_cnt      <= '0;
              timeout_pulse <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + TO_W'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
`endif
        end
        HOLD: begin
          if (io.pkt_ready) begin
            state       <= COLLECT;
            pkt_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= COLLECT;
          pkt_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.pkt_valid = pkt_valid_q;
  assign io.pkt_op    = shift[PACKET_BITS-1 -: OP_BITS];
  assign io.pkt_data  = shift[PACKET_BITS-OP_BITS-1:0];

  logic            ev_push;
  logic [EV_W-1:0] ev_word;
  logic [EV_W-1:0] fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_overflow;

  // Events carrying no tokens are not worth reporting to the host.
  assign ev_push = io.ev_valid && (io.ev_startstop != 2'b00);
  assign ev_word = {io.ev_proc, io.ev_startstop, io.stage};

  ttt_io_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ev_push),
    .push_data (ev_word),
    .pop       (io.out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  // When nothing is buffered the host still sees the live stage.
  assign io.out_valid = !fifo_empty;
  assign io.out_word  = fifo_empty ? {{PROC_BITS{1'b0}}, 2'b00, io.stage} : fifo_head;
  assign io.overflow  = fifo_overflow;

  logic unused_full;
  assign unused_full = fifo_full;
endmodule

// File: tb/tb_ttt_packet_io.sv
// tb/tb_ttt_packet_io.sv - directed self-checking bench for ttt_packet_io
module tb_ttt_packet_io;
`ifdef TTT_PACKET_IO_TIMEOUT_EN
  localparam int TO_CYC = 3;
`else
  localparam int TO_CYC = 255;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ttt_packet_io_if #(
    .IN_WIDTH    (8),
    .PACKET_BITS (16),
    .OP_BITS     (4),
    .PROC_BITS   (4)
  ) bus ();

`ifdef TTT_PACKET_IO_TIMEOUT_EN
  logic timeout_pulse;
`endif

  ttt_packet_io #(
    .IN_WIDTH       (8),
    .PACKET_BITS    (16),
    .OP_BITS        (4),
    .PROC_BITS      (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
`ifdef TTT_PACKET_IO_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_event(input logic [3:0] proc, input logic [1:0] ss, input logic [1:0] stg);
    bus.ev_valid     = 1'b1;
    bus.ev_proc      = proc;
    bus.ev_startstop = ss;
    bus.stage        = stg;
    step();
    bus.ev_valid     = 1'b0;
  endtask

  logic [7:0] ovf_exp [4];
  logic [7:0] sim_exp [4];

  initial begin
    checks = 0;
    errors = 0;
    ovf_exp = '{8'h15, 8'h2A, 8'h3F, 8'h44};
    sim_exp = '{8'h77, 8'h88, 8'h95, 8'hAE};

    rst_n            = 1'b0;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.pkt_ready    = 1'b0;
    bus.ev_proc      = '0;
    bus.ev_startstop = 2'b00;
    bus.ev_valid     = 1'b0;
    bus.stage        = 2'b10;
    bus.out_ready    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_pkt_valid", bus.pkt_valid, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_out_word_stage", bus.out_word, 8'h02);

    // Two-beat packet with core ready
    bus.pkt_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h1A;
    step();
    chk("p1_valid_after_beat1", bus.pkt_valid, 0);
    bus.in_data = 8'h5C;
    step();
    bus.in_valid = 1'b0;
    chk("p1_valid", bus.pkt_valid, 1);
    chk("p1_op", bus.pkt_op, 4'h1);
    chk("p1_data", bus.pkt_data, 12'hA5C);
    chk("p1_in_ready_hold", bus.in_ready, 0);
    step();
    chk("p1_valid_one_cycle", bus.pkt_valid, 0);
    chk("p1_in_ready_back", bus.in_ready, 1);

    // Backpressure: core stalls while host keeps offering beats
    bus.pkt_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h9A;
    step();
    bus.in_data = 8'hBC;
    step();
    bus.in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.pkt_valid, 1);
      chk("bp_op", bus.pkt_op, 4'h9);
      chk("bp_data", bus.pkt_data, 12'hABC);
    end
    bus.in_valid  = 1'b0;
    bus.pkt_ready = 1'b1;
    step();
    chk("bp_release_valid", bus.pkt_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h23;
    step();
    bus.in_data = 8'h45;
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.pkt_valid, 1);
    chk("bp_next_op", bus.pkt_op, 4'h2);
    chk("bp_next_data", bus.pkt_data, 12'h345);
    step();
    chk("bp_next_done", bus.pkt_valid, 0);

    // FIFO overflow: five events into a four-deep FIFO, host not popping
    send_event(4'h1, 2'b01, 2'b01);
    chk("ovf_first_visible", bus.out_valid, 1);
    chk("ovf_first_word", bus.out_word, 8'h15);
    send_event(4'h2, 2'b10, 2'b10);
    send_event(4'h3, 2'b11, 2'b11);
    send_event(4'h4, 2'b01, 2'b00);
    chk("ovf_not_yet", bus.overflow, 0);
    send_event(4'h5, 2'b10, 2'b01);
    chk("ovf_set", bus.overflow, 1);
    bus.stage     = 2'b11;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_valid", bus.out_valid, 1);
      chk("ovf_drain_word", bus.out_word, ovf_exp[i]);
      step();
    end
    chk("ovf_fifth_absent", bus.out_valid, 0);
    chk("ovf_empty_word", bus.out_word, 8'h03);
    chk("ovf_sticky", bus.overflow, 1);
    step();
    chk("pop_empty_noeffect", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Clear sticky overflow
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("ovf_cleared", bus.overflow, 0);

    // Simultaneous push and pop at full; zero-token events never buffered
    send_event(4'h6, 2'b11, 2'b10);
    send_event(4'h7, 2'b01, 2'b11);
    send_event(4'hF, 2'b00, 2'b01);
    send_event(4'h8, 2'b10, 2'b00);
    send_event(4'h9, 2'b01, 2'b01);
    send_event(4'hF, 2'b00, 2'b10);
    chk("sim_zero_no_ovf", bus.overflow, 0);
    chk("sim_head", bus.out_word, 8'h6E);
    bus.out_ready = 1'b1;
    send_event(4'hA, 2'b11, 2'b10);
    chk("sim_no_ovf", bus.overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("sim_drain_valid", bus.out_valid, 1);
      chk("sim_drain_word", bus.out_word, sim_exp[i]);
      step();
    end
    chk("sim_drained", bus.out_valid, 0);
    chk("sim_final_ovf", bus.overflow, 0);
    bus.out_ready = 1'b0;

    // Reset after the first beat discards it
    bus.pkt_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    step();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.pkt_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    step();
    chk("mid_rst_partial", bus.pkt_valid, 0);
    bus.in_data = 8'hD4;
    step();
    bus.in_valid = 1'b0;
    chk("mid_rst_valid2", bus.pkt_valid, 1);
    chk("mid_rst_op", bus.pkt_op, 4'h3);
    chk("mid_rst_data", bus.pkt_data, 12'hCD4);
    step();

`ifdef TTT_PACKET_IO_TIMEOUT_EN
    // One beat then idle: partial packet discarded after TIMEOUT_CYCLES
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("to_idle1", timeout_pulse, 0);
    step();
    chk("to_idle2", timeout_pulse, 0);
    step();
    chk("to_pulse", timeout_pulse, 1);
    step();
    chk("to_pulse_one_cycle", timeout_pulse, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hE1;
    step();
    chk("to_partial", bus.pkt_valid, 0);
    bus.in_data = 8'h0F;
    step();
    bus.in_valid = 1'b0;
    chk("to_valid", bus.pkt_valid, 1);
    chk("to_op", bus.pkt_op, 4'hE);
    chk("to_data", bus.pkt_data, 12'h10F);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
